// File: rtl/wd_pkg.sv
// Shared encodings for the windowed-watchdog block: FSM states, fault codes
// and the power-up phase length.
package wd_pkg;

  localparam logic [1:0] WD_IDLE   = 2'b00;
  localparam logic [1:0] WD_CLOSED = 2'b01;
  localparam logic [1:0] WD_OPEN   = 2'b10;
  localparam logic [1:0] WD_FAULT  = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_EARLY = 2'b01;
  localparam logic [1:0] FC_MISS  = 2'b10;

  localparam int DEF_LEN = 16;

endpackage

// File: rtl/wd_phase_counter.sv
// Phase cycle counter: restarts at 0 on clear, otherwise counts up and flags
// the final cycle of a phase of length len.
module wd_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             WDRST,
  input  logic             clear,
  input  logic [CNT_W-1:0] len,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge WDRST) begin
    if (WDRST)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  // len is never 0 because zero writes are stored as 1
  assign last = (cnt == len - CNT_W'(1));

endmodule

// File: rtl/wd_window_ctrl.sv
// Windowed-watchdog sequencer: alternates CLOSED/OPEN service windows, counts
// missed windows and latches a sticky fault on early service or miss limit.
module wd_window_ctrl
  import wd_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_MISS = 3
) (
  input  logic             CLK,
  input  logic             WDRST,
  input  logic             EN,
  input  logic             CFG_WE,
  input  logic [CNT_W-1:0] CFG_CLOSED,
  input  logic [CNT_W-1:0] CFG_OPEN,
  input  logic             WDSRVC,
  input  logic             CLR_FAULT,
  output logic             SRVC_ACK,
  output logic             WARN,
  output logic             CFG_ERR,
  output logic             FAULT,
  output logic [1:0]       FAULT_CODE,
  output logic [CNT_W-1:0] FWLEN,
  output logic [1:0]       STATE,
  output logic [3:0]       MISS_CNT
);

  logic [1:0]       st, st_nx;
  logic [CNT_W-1:0] closed_len, closed_nx, open_len, open_nx, fwlen_nx;
  logic [3:0]       miss, miss_nx;
  logic             fault, fault_nx;
  logic [1:0]       code, code_nx;
  logic             ack_nx, warn_nx, err_nx;
  logic             ack_q, warn_q, err_q;
  logic             clear, last;
  logic [CNT_W-1:0] phase_len;

  assign phase_len = (st == WD_OPEN) ? open_len : closed_len;

  wd_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .CLK   (CLK),
    .WDRST (WDRST),
    .clear (clear),
    .len   (phase_len),
    .last  (last)
  );

  // EN=0 outranks service, and service outranks expiry, inside a live window
  always_comb begin
    st_nx     = st;
    closed_nx = closed_len;
    open_nx   = open_len;
    miss_nx   = miss;
    fault_nx  = fault;
    code_nx   = code;
    ack_nx    = 1'b0;
    warn_nx   = 1'b0;
    err_nx    = 1'b0;

    if (CFG_WE) begin
      if (st == WD_IDLE) begin
        closed_nx = (CFG_CLOSED == '0) ? CNT_W'(1) : CFG_CLOSED;
        open_nx   = (CFG_OPEN == '0) ? CNT_W'(1) : CFG_OPEN;
      end else begin
        err_nx = 1'b1;
      end
    end

    case (st)
      WD_IDLE: begin
        if (EN)
          st_nx = WD_CLOSED;
      end
      WD_CLOSED: begin
        if (!EN) begin
          st_nx   = WD_IDLE;
          miss_nx = 4'd0;
        end else if (WDSRVC) begin
          st_nx    = WD_FAULT;
          fault_nx = 1'b1;
          code_nx  = FC_EARLY;
        end else if (last) begin
          st_nx = WD_OPEN;
        end
      end
      WD_OPEN: begin
        if (!EN) begin
          st_nx   = WD_IDLE;
          miss_nx = 4'd0;
        end else if (WDSRVC) begin
          st_nx   = WD_CLOSED;
          miss_nx = 4'd0;
          ack_nx  = 1'b1;
        end else if (last) begin
          warn_nx = 1'b1;
          miss_nx = miss + 4'd1;
          if (miss_nx == 4'(MAX_MISS)) begin
            st_nx    = WD_FAULT;
            fault_nx = 1'b1;
            code_nx  = FC_MISS;
          end else begin
            st_nx = WD_CLOSED;
          end
        end
      end
      default: begin
        if (CLR_FAULT && !EN) begin
          st_nx    = WD_IDLE;
          fault_nx = 1'b0;
          code_nx  = FC_NONE;
          miss_nx  = 4'd0;
        end
      end
    endcase

    fwlen_nx = (st_nx == WD_OPEN) ? open_nx : closed_nx;
    clear    = !(((st == WD_CLOSED) || (st == WD_OPEN)) && (st_nx == st));
  end

  always_ff @(posedge CLK or posedge WDRST) begin
    if (WDRST) begin
      st         <= WD_IDLE;
      closed_len <= CNT_W'(DEF_LEN);
      open_len   <= CNT_W'(DEF_LEN);
      FWLEN      <= CNT_W'(DEF_LEN);
      miss       <= 4'd0;
      fault      <= 1'b0;
      code       <= FC_NONE;
      ack_q      <= 1'b0;
      warn_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st         <= st_nx;
      closed_len <= closed_nx;
      open_len   <= open_nx;
      FWLEN      <= fwlen_nx;
      miss       <= miss_nx;
      fault      <= fault_nx;
      code       <= code_nx;
      ack_q      <= ack_nx;
      warn_q     <= warn_nx;
      err_q      <= err_nx;
    end
  end

  assign STATE      = st;
  assign MISS_CNT   = miss;
  assign FAULT      = fault;
  assign FAULT_CODE = code;
  assign SRVC_ACK   = ack_q;
  assign WARN       = warn_q;
  assign CFG_ERR    = err_q;

endmodule

// File: tb/tb_wd_window_ctrl.sv
// Directed bench for wd_window_ctrl: window sequencing, service, misses,
// early-service fault, config rules and asynchronous reset.
module tb_wd_window_ctrl;

  logic       CLK = 1'b0;
  logic       WDRST = 1'b1;
  logic       EN = 1'b0, CFG_WE = 1'b0, WDSRVC = 1'b0, CLR_FAULT = 1'b0;
  logic [7:0] CFG_CLOSED = 8'd0, CFG_OPEN = 8'd0;
  logic       SRVC_ACK, WARN, CFG_ERR, FAULT;
  logic [1:0] FAULT_CODE, STATE;
  logic [7:0] FWLEN;
  logic [3:0] MISS_CNT;

  int checks = 0;
  int errors = 0;

  wd_window_ctrl #(.CNT_W(8), .MAX_MISS(3)) dut (
    .CLK        (CLK),
    .WDRST      (WDRST),
    .EN         (EN),
    .CFG_WE     (CFG_WE),
    .CFG_CLOSED (CFG_CLOSED),
    .CFG_OPEN   (CFG_OPEN),
    .WDSRVC     (WDSRVC),
    .CLR_FAULT  (CLR_FAULT),
    .SRVC_ACK   (SRVC_ACK),
    .WARN       (WARN),
    .CFG_ERR    (CFG_ERR),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE),
    .FWLEN      (FWLEN),
    .STATE      (STATE),
    .MISS_CNT   (MISS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic en, input logic we, input logic [7:0] cl,
                               input logic [7:0] op, input logic srv, input logic clr);
    EN = en; CFG_WE = we; CFG_CLOSED = cl; CFG_OPEN = op; WDSRVC = srv; CLR_FAULT = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and land just after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    step();
    WDRST = 1'b1;
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 0);
    #2;
    checkOutput("rst_state", STATE, 2'b00);
    checkOutput("rst_fwlen", FWLEN, 8'd16);
    checkOutput("rst_fault", {FAULT, FAULT_CODE}, 3'b000);
    checkOutput("rst_miss", MISS_CNT, 4'd0);
    checkOutput("rst_pulses", {SRVC_ACK, WARN, CFG_ERR}, 3'b000);
    WDRST = 1'b0;
  endtask

  initial begin
    // A: sequencing with closed=4/open=3 and three unserviced windows
    doReset();
    applyStimulus(1, 1, 8'd4, 8'd3, 0, 0);
    step();
    checkOutput("a_c1_state", STATE, 2'b01);
    checkOutput("a_c1_fwlen", FWLEN, 8'd4);
    applyStimulus(1, 0, 8'd4, 8'd3, 0, 0);
    for (int c = 2; c <= 4; c++) begin
      step();
      checkOutput($sformatf("a_c%0d_closed", c), STATE, 2'b01);
    end
    step();
    checkOutput("a_c5_state", STATE, 2'b10);
    checkOutput("a_c5_fwlen", FWLEN, 8'd3);
    step();
    step();
    checkOutput("a_c7_state", STATE, 2'b10);
    checkOutput("a_c7_warn", WARN, 1'b0);
    step();
    checkOutput("a_c8_warn", WARN, 1'b1);
    checkOutput("a_c8_miss", MISS_CNT, 4'd1);
    checkOutput("a_c8_state", STATE, 2'b01);
    step();
    checkOutput("a_c9_warn", WARN, 1'b0);
    repeat (6) step();
    checkOutput("a_c15_warn", WARN, 1'b1);
    checkOutput("a_c15_miss", MISS_CNT, 4'd2);
    repeat (7) step();
    checkOutput("a_c22_warn", WARN, 1'b1);
    checkOutput("a_c22_state", STATE, 2'b11);
    checkOutput("a_c22_fault", {FAULT, FAULT_CODE}, 3'b110);
    checkOutput("a_c22_miss", MISS_CNT, 4'd3);
    step();
    checkOutput("a_c23_warn", WARN, 1'b0);
    checkOutput("a_c23_state", STATE, 2'b11);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 1);
    step();
    checkOutput("a_clr_state", STATE, 2'b00);
    checkOutput("a_clr_fault", {FAULT, FAULT_CODE}, 3'b000);
    checkOutput("a_clr_miss", MISS_CNT, 4'd0);

    // B: service mid-window and on the last OPEN cycle, config rules
    applyStimulus(1, 0, 8'd0, 8'd0, 0, 0);
    repeat (6) step();
    checkOutput("b_c6_state", STATE, 2'b10);
    WDSRVC = 1'b1;
    step();
    checkOutput("b_c7_ack", SRVC_ACK, 1'b1);
    checkOutput("b_c7_state", STATE, 2'b01);
    checkOutput("b_c7_miss", MISS_CNT, 4'd0);
    WDSRVC = 1'b0;
    step();
    checkOutput("b_c8_ack", SRVC_ACK, 1'b0);
    repeat (5) step();
    checkOutput("b_c13_state", STATE, 2'b10);
    WDSRVC = 1'b1;
    step();
    checkOutput("b_last_ack", SRVC_ACK, 1'b1);
    checkOutput("b_last_warn", WARN, 1'b0);
    checkOutput("b_last_state", STATE, 2'b01);
    WDSRVC = 1'b0;
    repeat (4) step();
    checkOutput("b_c18_state", STATE, 2'b10);
    applyStimulus(1, 1, 8'd0, 8'd5, 0, 0);
    step();
    checkOutput("b_cfgerr", CFG_ERR, 1'b1);
    checkOutput("b_cfgerr_fwlen", FWLEN, 8'd3);
    checkOutput("b_cfgerr_state", STATE, 2'b10);
    applyStimulus(0, 0, 8'd0, 8'd5, 1, 0);
    step();
    checkOutput("b_en0_state", STATE, 2'b00);
    checkOutput("b_en0_ack", SRVC_ACK, 1'b0);
    checkOutput("b_en0_fwlen", FWLEN, 8'd4);
    checkOutput("b_en0_cfgerr", CFG_ERR, 1'b0);
    applyStimulus(0, 1, 8'd0, 8'd5, 0, 0);
    step();
    checkOutput("b_zero_fwlen", FWLEN, 8'd1);
    checkOutput("b_zero_cfgerr", CFG_ERR, 1'b0);
    applyStimulus(0, 0, 8'd0, 8'd0, 1, 0);
    step();
    checkOutput("b_idle_srv_state", STATE, 2'b00);
    checkOutput("b_idle_srv_ack", {SRVC_ACK, FAULT}, 2'b00);
    applyStimulus(1, 0, 8'd0, 8'd0, 0, 0);
    step();
    checkOutput("b_len1_closed", STATE, 2'b01);
    checkOutput("b_len1_fwlen", FWLEN, 8'd1);
    step();
    checkOutput("b_len1_open", STATE, 2'b10);
    checkOutput("b_len1_open_fwlen", FWLEN, 8'd5);

    // D: early service in CLOSED latches a sticky fault
    doReset();
    applyStimulus(1, 1, 8'd4, 8'd3, 0, 0);
    step();
    applyStimulus(1, 0, 8'd4, 8'd3, 0, 0);
    step();
    WDSRVC = 1'b1;
    step();
    checkOutput("d_early_state", STATE, 2'b11);
    checkOutput("d_early_fault", {FAULT, FAULT_CODE}, 3'b101);
    applyStimulus(0, 0, 8'd4, 8'd3, 1, 0);
    step();
    checkOutput("d_sticky_state", STATE, 2'b11);
    checkOutput("d_sticky_ack", SRVC_ACK, 1'b0);
    checkOutput("d_sticky_code", FAULT_CODE, 2'b01);
    applyStimulus(1, 0, 8'd4, 8'd3, 0, 1);
    step();
    checkOutput("d_clr_en1_state", STATE, 2'b11);
    checkOutput("d_clr_en1_fault", FAULT, 1'b1);
    applyStimulus(0, 0, 8'd4, 8'd3, 0, 1);
    step();
    checkOutput("d_clr_state", STATE, 2'b00);
    checkOutput("d_clr_fault", {FAULT, FAULT_CODE}, 3'b000);

    // E: asynchronous reset in the middle of an OPEN window
    applyStimulus(1, 0, 8'd0, 8'd0, 0, 0);
    repeat (20) step();
    checkOutput("e_pre_state", STATE, 2'b10);
    checkOutput("e_pre_miss", MISS_CNT, 4'd2);
    #2;
    WDRST = 1'b1;
    #1;
    checkOutput("e_rst_state", STATE, 2'b00);
    checkOutput("e_rst_miss", MISS_CNT, 4'd0);
    checkOutput("e_rst_fwlen", FWLEN, 8'd16);
    checkOutput("e_rst_fault", {FAULT, FAULT_CODE, SRVC_ACK, WARN, CFG_ERR}, 6'b0);
    WDRST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
